// File: rtl/frame_dump_pkg.sv
// Shared types and byte codes for the UART-driven frame capture/dump controller.
package frame_dump_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CAP_PULSE,
    CAP_WAIT_HI,
    CAP_WAIT_LO,
    RD_PULSE,
    RD_WAIT_RRST,
    RD_STROBE,
    RD_WAIT_DATA,
    TX_WAIT,
    TX_PULSE,
    TX_GUARD,
    REPLY
  } state_e;

  localparam logic [7:0] CMD_CAPTURE   = 8'h43;
  localparam logic [7:0] CMD_DUMP      = 8'h52;
  localparam logic [7:0] CMD_STATUS    = 8'h53;

  localparam logic [7:0] RPL_UNKNOWN   = 8'h3F;
  localparam logic [7:0] RPL_ERROR     = 8'h45;
  localparam logic [7:0] RPL_OK        = 8'h4B;
  localparam logic [7:0] RPL_NOT_READY = 8'h4E;
  localparam logic [7:0] RPL_TIMEOUT   = 8'h54;

  // States that block on an external handshake and are guarded by the watchdog
  function automatic logic is_wait_state(input state_e s);
    return (s == CAP_WAIT_HI) || (s == CAP_WAIT_LO) ||
           (s == RD_WAIT_RRST) || (s == RD_WAIT_DATA);
  endfunction

endpackage

// File: rtl/dump_watchdog.sv
// Cycle watchdog: counts cycles while enabled, restarts on clear, flags the limit.
module dump_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 24000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at the limit so a stalled state cannot wrap back to zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= enable && (cnt_d == CNT_LAST);
    end
  end

endmodule

// File: rtl/frame_dump_ctrl.sv
// Command-driven camera capture and byte-by-byte frame dump over a UART link.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 153600,
  parameter int unsigned TIMEOUT_CYC = 24000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_en,
  input  logic       i_tx_busy,
  input  logic       i_cam_ready,
  output logic       o_capture_start,
  output logic       o_read_start,
  input  logic       i_fifo_rrst_done,
  output logic       o_rd_byte_str,
  input  logic       i_fifo_busy,
  input  logic       i_data_rdy,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_frame_valid
);

  localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] byte_cnt_d;
  logic [7:0]       tx_byte_q;
  logic [7:0]       tx_byte_d;
  logic             is_reply_q;
  logic             is_reply_d;
  logic             frame_valid_d;
  logic             timeout_c;
  logic             wd_clear_c;
  logic             wd_enable_c;
  logic             wd_expired;

  dump_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (wd_clear_c),
    .enable (wd_enable_c),
    .expired(wd_expired)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    tx_byte_d     = tx_byte_q;
    is_reply_d    = is_reply_q;
    frame_valid_d = o_frame_valid;
    timeout_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          is_reply_d = 1'b1;
          state_d    = REPLY;
          case (i_rx_data)
            CMD_CAPTURE: begin
              if (i_cam_ready) state_d = CAP_PULSE;
              else             tx_byte_d = RPL_NOT_READY;
            end
            CMD_DUMP: begin
              if (o_frame_valid) state_d = RD_PULSE;
              else               tx_byte_d = RPL_ERROR;
            end
            CMD_STATUS: tx_byte_d = {6'b0, o_frame_valid, i_cam_ready};
            default:    tx_byte_d = RPL_UNKNOWN;
          endcase
        end
      end

      CAP_PULSE: state_d = CAP_WAIT_HI;

      CAP_WAIT_HI: begin
        if (i_fifo_busy) state_d = CAP_WAIT_LO;
        else             timeout_c = wd_expired;
      end

      CAP_WAIT_LO: begin
        if (!i_fifo_busy) begin
          frame_valid_d = 1'b1;
          tx_byte_d     = RPL_OK;
          is_reply_d    = 1'b1;
          state_d       = REPLY;
        end else begin
          timeout_c = wd_expired;
        end
      end

      RD_PULSE: begin
        byte_cnt_d = '0;
        state_d    = RD_WAIT_RRST;
      end

      RD_WAIT_RRST: begin
        if (i_fifo_rrst_done) state_d = RD_STROBE;
        else                  timeout_c = wd_expired;
      end

      RD_STROBE: state_d = RD_WAIT_DATA;

      RD_WAIT_DATA: begin
        if (i_data_rdy) begin
          tx_byte_d  = i_data;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          is_reply_d = 1'b0;
          state_d    = TX_WAIT;
        end else begin
          timeout_c = wd_expired;
        end
      end

      TX_WAIT: begin
        if (!i_tx_busy) state_d = TX_PULSE;
      end

      TX_PULSE: state_d = TX_GUARD;

      // One byte in flight: the next fetch starts only after the guard cycle
      TX_GUARD: begin
        if (is_reply_q) begin
          state_d = IDLE;
        end else if (byte_cnt_q == LAST_CNT) begin
          frame_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = RD_STROBE;
        end
      end

      REPLY: state_d = TX_WAIT;

      default: state_d = IDLE;
    endcase

    if (timeout_c) begin
      frame_valid_d = 1'b0;
      tx_byte_d     = RPL_TIMEOUT;
      is_reply_d    = 1'b1;
      state_d       = REPLY;
    end

    // Watchdog restarts whenever a new state is entered
    wd_clear_c  = (state_d != state_q);
    wd_enable_c = is_wait_state(state_d);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      byte_cnt_q      <= '0;
      tx_byte_q       <= '0;
      is_reply_q      <= 1'b0;
      o_tx_data       <= '0;
      o_tx_en         <= 1'b0;
      o_capture_start <= 1'b0;
      o_read_start    <= 1'b0;
      o_rd_byte_str   <= 1'b0;
      o_busy          <= 1'b0;
      o_frame_valid   <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      tx_byte_q       <= tx_byte_d;
      is_reply_q      <= is_reply_d;
      o_tx_en         <= (state_d == TX_PULSE);
      o_capture_start <= (state_d == CAP_PULSE);
      o_read_start    <= (state_d == RD_PULSE);
      o_rd_byte_str   <= (state_d == RD_STROBE);
      o_busy          <= (state_d != IDLE);
      o_frame_valid   <= frame_valid_d;
      if (state_d == TX_PULSE) o_tx_data <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Directed/randomized bench for frame_dump_ctrl with behavioural peripherals and reply model.
module tb_frame_dump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;
  logic       cam_ready;
  logic       capture_start;
  logic       read_start;
  logic       rrst_done;
  logic       rd_byte_str;
  logic       fifo_busy;
  logic       data_rdy;
  logic [7:0] data;
  logic       busy;
  logic       frame_valid;

  logic uart_busy;
  logic hold_busy;
  assign tx_busy = uart_busy | hold_busy;

  always #5 clk = ~clk;

  frame_dump_ctrl #(
    .FRAME_BYTES(4),
    .TIMEOUT_CYC(100)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rx_done       (rx_done),
    .i_rx_data       (rx_data),
    .o_tx_data       (tx_data),
    .o_tx_en         (tx_en),
    .i_tx_busy       (tx_busy),
    .i_cam_ready     (cam_ready),
    .o_capture_start (capture_start),
    .o_read_start    (read_start),
    .i_fifo_rrst_done(rrst_done),
    .o_rd_byte_str   (rd_byte_str),
    .i_fifo_busy     (fifo_busy),
    .i_data_rdy      (data_rdy),
    .i_data          (data),
    .o_busy          (busy),
    .o_frame_valid   (frame_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_log[$];
  logic [7:0] fifo_q[$];
  int cap_pulses = 0, rd_starts = 0, rd_strobes = 0;
  int clash_cnt = 0, stab_viol = 0;
  logic [7:0] prev_tx = 8'h00;
  bit cap_coop = 1'b1;
  int stray_req = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: transmitted bytes, strobe counts, exclusivity and data stability
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (capture_start) cap_pulses++;
        if (read_start)    rd_starts++;
        if (rd_byte_str)   rd_strobes++;
        if (tx_en)         tx_log.push_back(tx_data);
        if ((int'(capture_start) + int'(read_start) + int'(rd_byte_str) + int'(tx_en)) > 1)
          clash_cnt++;
        if ((tx_data !== prev_tx) && !tx_en) stab_viol++;
      end
      prev_tx = tx_data;
    end
  end

  // UART transmitter: busy for a few cycles after every accepted byte
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        uart_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        uart_busy = 1'b0;
      end
    end
  end

  // Capture engine: goes busy for 10 cycles after a start, unless told to hang
  initial begin
    fifo_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (capture_start && cap_coop) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        fifo_busy = 1'b1;
        repeat (10) @(negedge clk);
        fifo_busy = 1'b0;
      end
    end
  end

  // Read-pointer reset acknowledge
  initial begin
    rrst_done = 1'b0;
    forever begin
      @(negedge clk);
      if (read_start) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        rrst_done = 1'b1;
        @(negedge clk);
        rrst_done = 1'b0;
      end
    end
  end

  // FIFO byte source; also issues unsolicited data_rdy pulses on request
  initial begin
    int stray_done;
    stray_done = 0;
    data_rdy = 1'b0;
    data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_byte_str) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if (fifo_q.size() > 0) data = fifo_q.pop_front();
        else                   data = 8'hEE;
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        data = 8'hA5;
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
      end
    end
  end

  // Reply predicted from the command rules and the bench's own view of frame state
  function automatic logic [7:0] ref_reply(input logic [7:0] cmd, input bit coop);
    case (cmd)
      8'h43:   return !cam_ready ? 8'h4E : (coop ? 8'h4B : 8'h54);
      8'h52:   return 8'h45;
      8'h53:   return {6'b0, m_valid, cam_ready};
      default: return 8'h3F;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k;
    k = 0;
    while ((tx_log.size() < n) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_arrived"}, 32'(tx_log.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic cmd_reply(input string tag, input logic [7:0] cmd);
    int base, caps;
    logic [7:0] exp;
    logic [31:0] obs;
    base = tx_log.size();
    caps = cap_pulses;
    exp  = ref_reply(cmd, cap_coop);
    if (cmd == 8'h43 && cam_ready) m_valid = cap_coop;
    send(cmd);
    wait_log(base + 1, tag);
    obs = (tx_log.size() > base) ? 32'(tx_log[base]) : 32'hFFFF_FFFF;
    chk(tag, obs, 32'(exp));
    wait_idle(tag);
    repeat (5) @(negedge clk);
    chk({tag, "_one_reply"}, 32'(tx_log.size()), 32'(base + 1));
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'(m_valid));
    chk({tag, "_cap_pulses"}, 32'(cap_pulses - caps),
        32'((cmd == 8'h43 && cam_ready) ? 1 : 0));
  endtask

  task automatic dump(input string tag, input bit fixed, input bit with_hold);
    int base, strobes, starts;
    logic [7:0] exp_b[4];
    for (int i = 0; i < 4; i++) begin
      exp_b[i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom_range(0, 255));
      fifo_q.push_back(exp_b[i]);
    end
    base    = tx_log.size();
    strobes = rd_strobes;
    starts  = rd_starts;
    send(8'h52);
    if (with_hold) begin
      wait_log(base + 2, {tag, "_pre_hold"});
      hold_busy = 1'b1;
      send(8'h53);
      repeat (48) @(negedge clk);
      chk({tag, "_held"}, 32'(tx_log.size()), 32'(base + 2));
      hold_busy = 1'b0;
    end
    wait_log(base + 4, tag);
    wait_idle(tag);
    repeat (8) @(negedge clk);
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (tx_log.size() > base + i) ? 32'(tx_log[base + i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
    chk({tag, "_byte_count"}, 32'(tx_log.size()), 32'(base + 4));
    chk({tag, "_strobes"}, 32'(rd_strobes - strobes), 32'd4);
    chk({tag, "_read_start"}, 32'(rd_starts - starts), 32'd1);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'(m_valid));
  endtask

  initial begin
    int base, k, strobes, caps, starts;
    logic [7:0] b;

    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; cam_ready = 1'b0; hold_busy = 1'b0;
    #1;
    chk("reset_outputs",
        32'({tx_data, tx_en, busy, frame_valid, capture_start, read_start, rd_byte_str}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    cmd_reply("status_cold", 8'h53);
    cmd_reply("capture_not_ready", 8'h43);
    cmd_reply("dump_no_frame", 8'h52);
    cmd_reply("unknown_Z", 8'h5A);
    for (int i = 0; i < 3; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h43 || b == 8'h52 || b == 8'h53);
      cmd_reply($sformatf("unknown_rand%0d", i), b);
    end

    cam_ready = 1'b1;
    cmd_reply("capture_ok", 8'h43);
    cmd_reply("status_valid", 8'h53);
    dump("dump_fixed", 1'b1, 1'b0);
    cmd_reply("dump_after_consume", 8'h52);

    // Capture engine never responds: watchdog reply after the limit
    cap_coop = 1'b0;
    base = tx_log.size();
    send(8'h43);
    k = 0;
    while ((tx_log.size() == base) && (k < 400)) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_reply", (tx_log.size() > base) ? 32'(tx_log[base]) : 32'hFFFF_FFFF, 32'h54);
    chk("timeout_latency", 32'(k >= 100 && k <= 106), 32'd1);
    wait_idle("timeout");
    m_valid = 1'b0;
    chk("timeout_frame_valid", 32'(frame_valid), 32'd0);
    cap_coop = 1'b1;

    cmd_reply("capture_ok2", 8'h43);
    dump("dump_hold", 1'b0, 1'b1);

    // Unsolicited data_rdy in IDLE must not produce traffic
    base = tx_log.size();
    stray_req++;
    repeat (10) @(negedge clk);
    chk("stray_rdy_no_tx", 32'(tx_log.size()), 32'(base));
    chk("stray_rdy_idle", 32'(busy), 32'd0);

    // Reset in the middle of a dump
    cmd_reply("capture_ok3", 8'h43);
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
    base = tx_log.size();
    send(8'h52);
    wait_log(base + 2, "pre_reset");
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        32'({tx_data, tx_en, busy, frame_valid, capture_start, read_start, rd_byte_str}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    base = tx_log.size();
    strobes = rd_strobes; caps = cap_pulses; starts = rd_starts;
    repeat (30) @(negedge clk);
    chk("post_reset_no_tx", 32'(tx_log.size()), 32'(base));
    chk("post_reset_no_strobes", 32'((rd_strobes - strobes) + (cap_pulses - caps) + (rd_starts - starts)), 32'd0);
    fifo_q.delete();
    cmd_reply("status_after_reset", 8'h53);

    chk("strobe_exclusive", 32'(clash_cnt), 32'd0);
    chk("tx_data_stable", 32'(stab_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
